// File: rtl/instr_aligner_pkg.sv
// Shared core definitions for the instruction aligner: widths, state encoding and
// the RVC length decode helper.
package instr_aligner_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned HALF_W  = 16;

  typedef enum logic [1:0] {
    ALIGNED,
    UNALIGNED,
    SKIP_LOW
  } aligner_state_e;

  // Any opcode whose two low bits are not 2'b11 is a 16-bit RVC instruction.
  function automatic logic is_compressed(input logic [1:0] lsbs);
    return lsbs != 2'b11;
  endfunction

endpackage

// File: rtl/instr_aligner_if.sv
// FIFO head, redirect and decode handshake signals seen by the instruction aligner.
// The master modport is the aligner itself; slave is the surrounding fetch/decode side.
interface instr_aligner_if;
  import instr_aligner_pkg::*;

  logic [INSTR_W-1:0] fifo_rd_data;
  logic               fifo_rd_data_valid;
  logic               fifo_rd_en;
  logic               fifo_clear;
  logic               redirect_valid;
  logic [INSTR_W-1:0] redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [INSTR_W-1:0] instr_pc;
  logic               instr_is_compressed;

  modport master (
    input  fifo_rd_data, fifo_rd_data_valid, redirect_valid, redirect_pc, instr_ready,
    output fifo_rd_en, fifo_clear, instr_valid, instr, instr_pc, instr_is_compressed
  );

  modport slave (
    output fifo_rd_data, fifo_rd_data_valid, redirect_valid, redirect_pc, instr_ready,
    input  fifo_rd_en, fifo_clear, instr_valid, instr, instr_pc, instr_is_compressed
  );

endinterface

// File: rtl/instr_aligner.sv
// Realigns 32-bit fetch words from a show-ahead FIFO into whole RV32IC instructions
// and presents them one at a time, with their PC, to decode.
module instr_aligner
  import instr_aligner_pkg::*;
#(
  parameter logic [INSTR_W-1:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset_n,
  instr_aligner_if.master bus_io
);

  aligner_state_e     state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [HALF_W-1:0]  hold_q, hold_d;

  logic [INSTR_W-1:0] head;
  logic               head_valid;
  logic               can_acc;
  logic               acc;
  logic               valid;
  logic               rd_en;
  logic               clear;
  logic [INSTR_W-1:0] instr_w;

  assign head       = bus_io.fifo_rd_data;
  assign head_valid = bus_io.fifo_rd_data_valid;
  // A redirect drops whatever is presented, so it can never be accepted.
  assign can_acc    = bus_io.instr_ready & ~bus_io.redirect_valid & reset_n;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    valid   = 1'b0;
    rd_en   = 1'b0;
    clear   = 1'b0;
    acc     = 1'b0;
    instr_w = {{HALF_W{1'b0}}, head[HALF_W-1:0]};

    case (state_q)
      ALIGNED: begin
        valid = head_valid;
        if (!is_compressed(head[1:0])) begin
          instr_w = head;
        end
        acc = valid & can_acc;
        if (acc) begin
          rd_en = 1'b1;
          if (is_compressed(head[1:0])) begin
            hold_d  = head[INSTR_W-1:HALF_W];
            state_d = UNALIGNED;
            pc_d    = pc_q + 32'd2;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end

      UNALIGNED: begin
        if (is_compressed(hold_q[1:0])) begin
          // The buffered halfword is a complete instruction; no FIFO data needed.
          valid   = 1'b1;
          instr_w = {{HALF_W{1'b0}}, hold_q};
          acc     = can_acc;
          if (acc) begin
            state_d = ALIGNED;
            pc_d    = pc_q + 32'd2;
          end
        end else begin
          valid   = head_valid;
          instr_w = {head[HALF_W-1:0], hold_q};
          acc     = valid & can_acc;
          if (acc) begin
            rd_en  = 1'b1;
            hold_d = head[INSTR_W-1:HALF_W];
            pc_d   = pc_q + 32'd4;
          end
        end
      end

      SKIP_LOW: begin
        // Redirect landed on an upper halfword: discard the low half of the first word.
        if (head_valid && reset_n) begin
          rd_en   = 1'b1;
          hold_d  = head[INSTR_W-1:HALF_W];
          state_d = UNALIGNED;
        end
      end

      default: begin
        state_d = ALIGNED;
      end
    endcase

    if (bus_io.redirect_valid) begin
      clear   = 1'b1;
      rd_en   = 1'b0;
      valid   = 1'b0;
      pc_d    = bus_io.redirect_pc & ~32'h1;
      hold_d  = '0;
      state_d = bus_io.redirect_pc[1] ? SKIP_LOW : ALIGNED;
    end

    if (!reset_n) begin
      valid = 1'b0;
      rd_en = 1'b0;
      clear = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ALIGNED;
      pc_q    <= BOOT_ADDR & ~32'h1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  assign bus_io.fifo_rd_en          = rd_en;
  assign bus_io.fifo_clear          = clear;
  assign bus_io.instr_valid         = valid;
  assign bus_io.instr               = instr_w;
  assign bus_io.instr_pc            = pc_q;
  assign bus_io.instr_is_compressed = is_compressed(instr_w[1:0]);

endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: directed vector table, hand-written corner sequences and a
// randomized run checked against an address-level model of the instruction stream.
module tb_instr_aligner;

  logic clk;
  logic reset_n;

  instr_aligner_if bus ();

  instr_aligner #(
    .BOOT_ADDR(32'h8000_0000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] data, input logic dv, input logic rdy,
                       input logic redir, input logic [31:0] rpc);
    bus.fifo_rd_data       = data;
    bus.fifo_rd_data_valid = dv;
    bus.instr_ready        = rdy;
    bus.redirect_valid     = redir;
    bus.redirect_pc        = rpc;
  endtask

  typedef struct {
    logic [31:0] data;
    logic        dv;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] epc;
    logic        ec;
    logic        erd;
  } vec_t;

  vec_t vecs[15];

  // Program image for the random run: halfword at address a is mem[a[8:1]].
  logic [15:0] mem[256];

  function automatic logic [15:0] half_at(input logic [31:0] a);
    return mem[a[8:1]];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {half_at(a + 32'd2), half_at(a)};
  endfunction

  logic [31:0] fifo_q[$];

  initial begin
    logic [31:0] mpc;
    logic [31:0] fa;
    logic [31:0] fa_next;
    logic [31:0] tgt;
    logic [31:0] exp_i;
    logic [15:0] h0;
    logic        redir;
    logic        rd_s;
    logic        clr_s;
    logic        prev_hold;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;
    int          accepted;

    vecs[0]  = '{32'h00A0_0093, 1'b1, 1'b1, 1'b1, 32'h00A0_0093, 32'h8000_0000, 1'b0, 1'b1};
    vecs[1]  = '{32'h4501_4481, 1'b1, 1'b1, 1'b1, 32'h0000_4481, 32'h8000_0004, 1'b1, 1'b1};
    vecs[2]  = '{32'h0093_0001, 1'b1, 1'b1, 1'b1, 32'h0000_4501, 32'h8000_0006, 1'b1, 1'b0};
    vecs[3]  = '{32'h0093_0001, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 32'h8000_0008, 1'b1, 1'b1};
    vecs[4]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,         32'h8000_000A, 1'b0, 1'b0};
    vecs[5]  = '{32'h1234_00A0, 1'b1, 1'b0, 1'b1, 32'h00A0_0093, 32'h8000_000A, 1'b0, 1'b0};
    vecs[6]  = '{32'h1234_00A0, 1'b1, 1'b0, 1'b1, 32'h00A0_0093, 32'h8000_000A, 1'b0, 1'b0};
    vecs[7]  = '{32'h1234_00A0, 1'b1, 1'b0, 1'b1, 32'h00A0_0093, 32'h8000_000A, 1'b0, 1'b0};
    vecs[8]  = '{32'h1234_00A0, 1'b1, 1'b1, 1'b1, 32'h00A0_0093, 32'h8000_000A, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 32'h8000_000E, 1'b1, 1'b0};
    vecs[10] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,         32'h8000_0010, 1'b0, 1'b0};
    vecs[11] = '{32'h00A0_0093, 1'b1, 1'b0, 1'b1, 32'h00A0_0093, 32'h8000_0010, 1'b0, 1'b0};
    vecs[12] = '{32'h00A0_0093, 1'b1, 1'b0, 1'b1, 32'h00A0_0093, 32'h8000_0010, 1'b0, 1'b0};
    vecs[13] = '{32'h00A0_0093, 1'b1, 1'b0, 1'b1, 32'h00A0_0093, 32'h8000_0010, 1'b0, 1'b0};
    vecs[14] = '{32'h00A0_0093, 1'b1, 1'b1, 1'b1, 32'h00A0_0093, 32'h8000_0010, 1'b0, 1'b1};

    // Reset with a valid head present: nothing may be emitted or popped.
    reset_n = 1'b0;
    drive(32'h00A0_0093, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    check1("reset_valid", bus.instr_valid, 1'b0);
    check1("reset_rd_en", bus.fifo_rd_en, 1'b0);
    check1("reset_clear", bus.fifo_clear, 1'b0);
    check("reset_pc", bus.instr_pc, 32'h8000_0000);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].data, vecs[i].dv, vecs[i].rdy, 1'b0, 32'h0);
      #1;
      check1($sformatf("vec%0d_valid", i), bus.instr_valid, vecs[i].ev);
      check1($sformatf("vec%0d_rd_en", i), bus.fifo_rd_en, vecs[i].erd);
      check1($sformatf("vec%0d_clear", i), bus.fifo_clear, 1'b0);
      check($sformatf("vec%0d_pc", i), bus.instr_pc, vecs[i].epc);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_instr", i), bus.instr, vecs[i].ei);
        check1($sformatf("vec%0d_comp", i), bus.instr_is_compressed, vecs[i].ec);
      end
      @(negedge clk);
    end

    // Redirect to an upper halfword while a valid instruction is being accepted.
    drive(32'h00A0_0093, 1'b1, 1'b1, 1'b1, 32'h8000_0102);
    #1;
    check1("redir_clear", bus.fifo_clear, 1'b1);
    check1("redir_valid", bus.instr_valid, 1'b0);
    check1("redir_rd_en", bus.fifo_rd_en, 1'b0);
    @(negedge clk);
    drive(32'hABCD_1234, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    check1("skip_valid", bus.instr_valid, 1'b0);
    check1("skip_rd_en", bus.fifo_rd_en, 1'b1);
    @(negedge clk);
    drive(32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    check1("skip_out_valid", bus.instr_valid, 1'b1);
    check("skip_out_instr", bus.instr, 32'h0000_ABCD);
    check("skip_out_pc", bus.instr_pc, 32'h8000_0102);
    check1("skip_out_rd_en", bus.fifo_rd_en, 1'b0);
    @(negedge clk);

    // Back-to-back redirects: the second, word-aligned target must win.
    drive(32'h00A0_0093, 1'b1, 1'b1, 1'b1, 32'h8000_0202);
    #1;
    check1("b2b1_clear", bus.fifo_clear, 1'b1);
    @(negedge clk);
    drive(32'h00A0_0093, 1'b1, 1'b1, 1'b1, 32'h8000_0300);
    #1;
    check1("b2b2_clear", bus.fifo_clear, 1'b1);
    @(negedge clk);
    drive(32'h00A0_0093, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    check1("b2b_valid", bus.instr_valid, 1'b1);
    check("b2b_instr", bus.instr, 32'h00A0_0093);
    check("b2b_pc", bus.instr_pc, 32'h8000_0300);
    check1("b2b_rd_en", bus.fifo_rd_en, 1'b1);
    @(negedge clk);

    // Reset while holding the low half of a straddling 32-bit instruction.
    drive(32'h0093_0001, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    check("pre_rst_instr", bus.instr, 32'h0000_0001);
    @(negedge clk);
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check1("straddle_wait_valid", bus.instr_valid, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_pc", bus.instr_pc, 32'h8000_0000);
    @(negedge clk);
    reset_n = 1'b1;
    drive(32'h00A0_0093, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    check1("post_rst_valid", bus.instr_valid, 1'b1);
    check("post_rst_instr", bus.instr, 32'h00A0_0093);
    check("post_rst_pc", bus.instr_pc, 32'h8000_0000);
    @(negedge clk);
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized run against the address-level model.
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) mem[i][1:0] = 2'b11;
    end
    mpc        = 32'h0;
    fa         = 32'h0;
    fa_next    = 32'h0;
    prev_hold  = 1'b0;
    prev_instr = 32'h0;
    prev_pc    = 32'h0;
    accepted   = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      redir = (cyc == 0) || ($urandom_range(0, 39) == 0);
      tgt   = (cyc == 0) ? 32'hFFFF_FFFE : ($urandom & ~32'h1);
      bus.redirect_valid = redir;
      bus.redirect_pc    = tgt;
      bus.instr_ready    = ($urandom_range(0, 3) != 0);
      #1;
      check1("rnd_rd_en_needs_head", bus.fifo_rd_en & ~bus.fifo_rd_data_valid, 1'b0);
      if (redir) begin
        check1("rnd_redir_clear", bus.fifo_clear, 1'b1);
        check1("rnd_redir_valid", bus.instr_valid, 1'b0);
        check1("rnd_redir_rd_en", bus.fifo_rd_en, 1'b0);
        mpc     = tgt;
        fa_next = tgt & ~32'h3;
      end else begin
        check1("rnd_clear", bus.fifo_clear, 1'b0);
        if (prev_hold) begin
          check1("rnd_stable_valid", bus.instr_valid, 1'b1);
          check("rnd_stable_instr", bus.instr, prev_instr);
          check("rnd_stable_pc", bus.instr_pc, prev_pc);
        end
        if (bus.instr_valid) begin
          h0    = half_at(mpc);
          exp_i = (h0[1:0] != 2'b11) ? {16'h0, h0} : {half_at(mpc + 32'd2), h0};
          check("rnd_pc", bus.instr_pc, mpc);
          check("rnd_instr", bus.instr, exp_i);
          check1("rnd_comp", bus.instr_is_compressed, h0[1:0] != 2'b11);
          if (bus.instr_ready) begin
            mpc = mpc + ((h0[1:0] != 2'b11) ? 32'd2 : 32'd4);
            accepted++;
          end
        end
      end
      prev_hold  = ~redir & bus.instr_valid & ~bus.instr_ready;
      prev_instr = bus.instr;
      prev_pc    = bus.instr_pc;
      rd_s       = bus.fifo_rd_en;
      clr_s      = bus.fifo_clear;
      @(posedge clk);
      #1;
      if (clr_s) begin
        fifo_q.delete();
        fa = fa_next;
      end else if (rd_s && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
      end
      if (fifo_q.size() < 4 && $urandom_range(0, 2) != 0) begin
        fifo_q.push_back(word_at(fa));
        fa = fa + 32'd4;
      end
      if (fifo_q.size() > 0) begin
        bus.fifo_rd_data       = fifo_q[0];
        bus.fifo_rd_data_valid = 1'b1;
      end else begin
        bus.fifo_rd_data       = 32'h0;
        bus.fifo_rd_data_valid = 1'b0;
      end
      @(negedge clk);
    end
    check1("rnd_progress", accepted > 200, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
